// File: rtl/mem_responder.sv
// Word-addressed main memory responder: fixed-latency request/done handshake
// with WAIT_STATES wait cycles; out-of-range and read+write requests flagged.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  done_q, done_d, err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0]  idx;
  logic                  accept, acc, oor, illegal, mem_we;

  assign idx     = addr_q[ADDR_BITS-1:0];
  assign accept  = (state_q == S_IDLE) && (mem_read || mem_write);
  assign acc     = (state_q == S_ACCESS);
  assign oor     = |addr_q[31:ADDR_BITS];
  assign illegal = rd_q && wr_q;

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (mem_read || mem_write)
                  state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_q == 4'd0) state_d = S_ACCESS;
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    busy    = (state_q != S_IDLE);
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (accept) begin
      cnt_d   = WAIT_INIT;
      addr_d  = address;
      wdata_d = data_in;
      rd_d    = mem_read;
      wr_d    = mem_write;
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    done_d = acc;
    err_d  = acc && (oor || illegal);
    mem_we = acc && wr_q && !rd_q && !oor;
    dout_d = dout_q;
    // An out-of-range read returns zero; an illegal request leaves data_out alone
    if (acc && rd_q && !wr_q) dout_d = oor ? '0 : mem_q[idx];
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; contents survive clear
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx] <= wdata_q;
  end

  assign data_out = dout_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed 512 x 32 main memory (Mem[0..511]) acting as the responder on the datapath's memory interface.
- The datapath is the initiator: MAR drives the address, MDR drives write data, and read data returns to the MDR input mux.
- Fixed-latency request/done handshake with a parameterised number of wait states.
- Out-of-range and illegal requests are flagged, never executed.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_BITS, 9, index bits actually decoded (DEPTH = 2**ADDR_BITS = 512)
WAIT_STATES, 2, extra cycles inserted before the access executes (legal range 0..15)

Ports:
clock  input  1  system clock, rising-edge
clear  input  1  asynchronous, active-low reset
mem_read  input  1  read request strobe, sampled only in IDLE
mem_write  input  1  write request strobe, sampled only in IDLE
address  input  32  word address (MAR contents)
data_in  input  32  write data (MDR contents)
data_out  output  32  read data to the MDR input mux
busy  output  1  high while a request is in flight (WAIT or ACCESS)
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (clear=0, asynchronous):
  - Outputs: state=IDLE, wait counter=0, data_out=0, busy=0, done=0, err=0.
  - Memory array contents are not affected by reset and are undefined at power-up.
  - Reset during WAIT or ACCESS aborts the request; a pending write never reaches the array.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - On a rising edge with mem_read or mem_write high, capture address, data_in and the op into internal registers.
  - Next state is WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0; otherwise next state is ACCESS.
  - The initiator may deassert strobes or change address/data after the accept edge; the captured values are used.
- WAIT:
  - Decrement the counter each edge.
  - When counter==0, the next state is ACCESS.
  - Strobes are ignored.
- ACCESS, single edge, always followed by IDLE:
  - Valid write: Mem[addr[8:0]] <= captured data. data_out is unchanged.
  - Valid read: data_out <= Mem[addr[8:0]].
  - In both cases done <= 1.
- Error cases (evaluated at ACCESS):
  - Captured address bits [31:9] nonzero: no array write; on a read, data_out <= 0; done <= 1; err <= 1.
  - Both mem_read and mem_write high at accept: illegal; no array access; data_out unchanged; done <= 1; err <= 1.
- done and err are registered, high for exactly one cycle (the first IDLE cycle after ACCESS), then return to 0.
- data_out holds its value until the next successful read or error read completes.
- busy=1 in WAIT and ACCESS, 0 in IDLE.
- Latency: done rises WAIT_STATES+1 edges after the accept edge.
- Back-to-back requests:
  - A new request may be accepted on the edge that ends the done cycle.
  - Throughput is one op per WAIT_STATES+2 cycles.
- Read-after-write to the same address in consecutive ops returns the newly written value.

Test Plan:
- Reset check: clear=0 mid-run -> data_out=0, busy=0, done=0, err=0 immediately, without waiting for a clock edge.
- Write then read:
  - With WAIT_STATES=2, write 0xDEADBEEF to address 0x1F5 -> done pulses 3 edges after accept, err=0.
  - Read 0x1F5 -> data_out=0xDEADBEEF when done=1, and held afterwards.
- Boundaries: write 0x00000001 to address 0 and 0xFFFFFFFF to address 511, then read both back -> exact values returned, err=0.
- Out of range:
  - Write 0x12345678 to address 0x200 -> done=1, err=1.
  - A subsequent read of address 0x000 returns its prior value (no wrap-around write).
  - A read of address 0x200 returns data_out=0 with err=1.
- Illegal request and strobe handling:
  - mem_read=mem_write=1 -> done=1, err=1, data_out unchanged.
  - Strobes toggled during WAIT are ignored; busy stays 1.
- Reset abort: issue a write of 0xAAAA5555 to address 5, assert clear during WAIT -> no done pulse; a later read of address 5 returns its old value.
